// File: rtl/qdi_tx_pkg.sv
// Shared definitions for the synchronous-to-QDI 1-of-4 transmitter.
package qdi_tx_pkg;

  localparam int unsigned DefaultDw   = 32;
  localparam int unsigned DefaultScn  = DefaultDw / 2;
  localparam int unsigned DefaultSync = 2;
  localparam int unsigned CntW        = 16;

  // Dibit value carried by each rail of a 1-of-4 sub-channel.
  localparam logic [1:0] RailZero  = 2'd0;
  localparam logic [1:0] RailOne   = 2'd1;
  localparam logic [1:0] RailTwo   = 2'd2;
  localparam logic [1:0] RailThree = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StRtz
  } qdi_state_e;

endpackage

// File: rtl/ack_sync.sv
// N-bit multi-stage synchronizer with async clear, plus a flag that rises once
// the last stage holds a real sample taken after reset release.
module ack_sync #(
  parameter int unsigned N    = 16,
  parameter int unsigned SYNC = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o,
  output logic         settled_o
);

  logic [SYNC-1:0][N-1:0] sync_q;
  logic [SYNC-1:0]        fill_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], d_i};
      fill_q <= {fill_q[SYNC-2:0], 1'b1};
    end
  end

  assign q_o       = sync_q[SYNC-1];
  assign settled_o = fill_q[SYNC-1];

endmodule

// File: rtl/qdi_tx.sv
// Transmits synchronous words onto 1-of-4 QDI rails using a 4-phase handshake
// with per-sub-channel acks synchronized into the clock domain.
module qdi_tx
  import qdi_tx_pkg::*;
#(
  parameter int unsigned DW   = DefaultDw,
  parameter int unsigned SCN  = DW / 2,
  parameter int unsigned SYNC = DefaultSync
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   in_data,
  input  logic            in_eof,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SCN-1:0]  o0,
  output logic [SCN-1:0]  o1,
  output logic [SCN-1:0]  o2,
  output logic [SCN-1:0]  o3,
  output logic            o4,
  input  logic [SCN-1:0]  oa,
  output logic [CntW-1:0] tx_cnt
);

  qdi_state_e     state_q;
  logic           xfer_q;
  logic [SCN-1:0] oa_sync;
  logic           sync_ok;
  logic           ack_all;
  logic           ack_none;
  logic [SCN-1:0] enc0, enc1, enc2, enc3;

  ack_sync #(
    .N    (SCN),
    .SYNC (SYNC)
  ) u_ack_sync (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .d_i       (oa),
    .q_o       (oa_sync),
    .settled_o (sync_ok)
  );

  assign ack_all  = &oa_sync;
  // Cleared sync flops read as "no ack"; wait for real samples before trusting that.
  assign ack_none = ~|oa_sync & sync_ok;

  always_comb begin
    enc0 = '0;
    enc1 = '0;
    enc2 = '0;
    enc3 = '0;
    for (int unsigned k = 0; k < SCN; k++) begin
      enc0[k] = (in_data[2*k +: 2] == RailZero);
      enc1[k] = (in_data[2*k +: 2] == RailOne);
      enc2[k] = (in_data[2*k +: 2] == RailTwo);
      enc3[k] = (in_data[2*k +: 2] == RailThree);
    end
  end

  // xfer_q marks an RTZ that follows a real data phase, so only those are counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRtz;
      xfer_q   <= 1'b0;
      in_ready <= 1'b0;
      o0       <= '0;
      o1       <= '0;
      o2       <= '0;
      o3       <= '0;
      o4       <= 1'b0;
      tx_cnt   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            o0       <= enc0;
            o1       <= enc1;
            o2       <= enc2;
            o3       <= enc3;
            o4       <= in_eof;
            in_ready <= 1'b0;
            state_q  <= StData;
          end
        end
        StData: begin
          if (ack_all) begin
            o0      <= '0;
            o1      <= '0;
            o2      <= '0;
            o3      <= '0;
            o4      <= 1'b0;
            xfer_q  <= 1'b1;
            state_q <= StRtz;
          end
        end
        StRtz: begin
          if (ack_none) begin
            if (xfer_q) begin
              tx_cnt <= tx_cnt + 1'b1;
            end
            xfer_q   <= 1'b0;
            in_ready <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: begin
          state_q <= StRtz;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qdi_tx.sv
// Scoreboard bench for qdi_tx: directed words, downstream 4-phase ack model.
module tb_qdi_tx;

  typedef struct packed {
    logic [15:0] o0;
    logic [15:0] o1;
    logic [15:0] o2;
    logic [15:0] o3;
    logic        o4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_eof;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] o0, o1, o2, o3;
  logic        o4;
  logic [15:0] oa;
  logic [15:0] tx_cnt;

  int          n_cmp  = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  bit          auto_ack = 1'b1;
  int          ack_dly  = 3;
  logic [15:0] man_oa   = '0;

  always #5 clk = ~clk;

  qdi_tx #(
    .DW   (32),
    .SCN  (16),
    .SYNC (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_eof   (in_eof),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o4       (o4),
    .oa       (oa),
    .tx_cnt   (tx_cnt)
  );

  function automatic logic rails_full();
    return &(o0 | o1 | o2 | o3);
  endfunction

  function automatic logic rails_zero();
    return ~|{o0, o1, o2, o3, o4};
  endfunction

  function automatic exp_t enc(input logic [31:0] d, input logic e);
    exp_t x;
    x = '0;
    for (int k = 0; k < 16; k++) begin
      case (d[2*k +: 2])
        2'd0: x.o0[k] = 1'b1;
        2'd1: x.o1[k] = 1'b1;
        2'd2: x.o2[k] = 1'b1;
        default: x.o3[k] = 1'b1;
      endcase
    end
    x.o4 = e;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Downstream 4-phase stage: ack after ack_dly cycles of full data, drop after zero rails.
  initial begin
    int cnt;
    cnt = 0;
    oa  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!auto_ack) begin
        oa  = man_oa;
        cnt = 0;
      end else if (rails_full() && oa != 16'hFFFF) begin
        if (cnt >= ack_dly) begin
          oa  = 16'hFFFF;
          cnt = 0;
        end else cnt++;
      end else if (rails_zero() && oa != 16'h0000) begin
        if (cnt >= ack_dly) begin
          oa  = 16'h0000;
          cnt = 0;
        end else cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard at each data-phase start.
  initial begin
    logic prev_dp;
    logic dp;
    int   bad;
    exp_t x;
    prev_dp = 1'b0;
    forever begin
      @(negedge clk);
      dp = rails_full();
      if (rst_n === 1'b1) begin
        if (dp && !prev_dp) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", {o0, o1, o2, o3, o4}, 80'd0);
          end else begin
            x = sb.pop_front();
            chk("word_rails", {o0, o1, o2, o3, o4}, x);
          end
          bad = 0;
          for (int k = 0; k < 16; k++) begin
            if (int'(o0[k]) + int'(o1[k]) + int'(o2[k]) + int'(o3[k]) != 1) bad++;
          end
          chk("one_hot_subch", bad, 0);
        end
        if (!dp && prev_dp) chk("rtz_rails_zero", rails_zero(), 1'b1);
        if (in_ready) chk("ready_only_idle", rails_zero(), 1'b1);
      end
      prev_dp = dp;
    end
  end

  task automatic send(input logic [31:0] d, input logic e, input exp_t x, input bit hold);
    int t;
    @(negedge clk);
    in_data  = d;
    in_eof   = e;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("send_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    @(negedge clk);
    while (!(in_ready && sb.size() == 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!(in_ready && sb.size() == 0)) chk({nm, "_idle_timeout"}, in_ready, 1'b1);
  endtask

  task automatic wait_full(input string nm);
    int t;
    t = 0;
    while (!rails_full() && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rails_full()) chk({nm, "_data_timeout"}, rails_full(), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    bit   ready_seen;
    exp_t xp;
    rst_n    = 1'b0;
    in_data  = '0;
    in_eof   = 1'b0;
    in_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_rails", {o0, o1, o2, o3, o4}, 80'd0);
    chk("rst_cnt", tx_cnt, 16'd0);
    rst_n = 1'b1;
    wait_idle("post_reset");
    chk("post_reset_cnt", tx_cnt, 16'd0);

    // Single word, ack 3 cycles after data
    xp = '{o0: 16'hFFF8, o1: 16'h0004, o2: 16'h0002, o3: 16'h0001, o4: 1'b0};
    send(32'h0000_001B, 1'b0, xp, 1'b0);
    wait_idle("single");
    chk("single_cnt", tx_cnt, 16'd1);

    // EOF word
    xp = '{o0: 16'h0000, o1: 16'h0000, o2: 16'h0000, o3: 16'hFFFF, o4: 1'b1};
    send(32'hFFFF_FFFF, 1'b1, xp, 1'b0);
    wait_idle("eof");
    chk("eof_cnt", tx_cnt, 16'd2);

    // Partial ack holds the data phase
    auto_ack = 1'b0;
    man_oa   = 16'h0000;
    xp = '{o0: 16'h0000, o1: 16'h00FF, o2: 16'hFF00, o3: 16'h0000, o4: 1'b0};
    send(32'hAAAA_5555, 1'b0, xp, 1'b0);
    wait_full("partial");
    man_oa = 16'h7FFF;
    repeat (20) begin
      @(negedge clk);
      chk("partial_hold", {in_ready, o0, o1, o2, o3, o4}, {1'b0, xp});
    end
    man_oa = 16'hFFFF;
    @(posedge clk);
    #3;
    n = 0;
    while (!rails_zero() && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("partial_rtz_latency", n, 3);
    man_oa = 16'h0000;
    wait_idle("partial");
    chk("partial_cnt", tx_cnt, 16'd3);
    auto_ack = 1'b1;

    // Back-to-back with in_valid held high
    ack_dly = 0;
    for (int i = 0; i < 100; i++) begin
      logic [31:0] d;
      d = 32'h9E37_79B9 * (i + 1);
      send(d, (i % 7) == 0, enc(d, (i % 7) == 0), 1'b1);
    end
    in_valid = 1'b0;
    wait_idle("b2b");
    chk("b2b_cnt", tx_cnt, 16'd103);

    // Counter wrap
    force dut.tx_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.tx_cnt;
    xp = '{o0: 16'hFFFF, o1: 16'h0000, o2: 16'h0000, o3: 16'h0000, o4: 1'b0};
    send(32'h0000_0000, 1'b0, xp, 1'b0);
    wait_idle("wrap1");
    chk("wrap_cnt_ffff", tx_cnt, 16'hFFFF);
    send(32'h0000_0000, 1'b0, xp, 1'b0);
    wait_idle("wrap2");
    chk("wrap_cnt_0000", tx_cnt, 16'h0000);
    send(32'h0000_0000, 1'b0, xp, 1'b0);
    wait_idle("wrap3");
    chk("wrap_cnt_0001", tx_cnt, 16'h0001);

    // Reset mid-DATA with all acks high
    auto_ack = 1'b0;
    man_oa   = 16'h0000;
    xp = '{o0: 16'hFFF8, o1: 16'h0004, o2: 16'h0002, o3: 16'h0001, o4: 1'b0};
    send(32'h0000_001B, 1'b0, xp, 1'b0);
    wait_full("rst_mid");
    man_oa = 16'hFFFF;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rails", {o0, o1, o2, o3, o4}, 80'd0);
    chk("rst_mid_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready) ready_seen = 1'b1;
    end
    chk("rst_mid_ready_held", ready_seen, 1'b0);
    chk("rst_mid_cnt", tx_cnt, 16'd0);
    man_oa = 16'h0000;
    wait_idle("rst_mid");
    chk("rst_mid_cnt_after", tx_cnt, 16'd0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
